// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the serial receiver and the register block.
// Tracks drops on overflow and drives RTS-style flow control with hysteresis.
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int HIGH_MARK = 12,
   parameter int LOW_MARK  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_stb,
   input  logic [7:0]               wr_data,
   input  logic                     rd_ack,
   input  logic                     flush,
   input  logic                     clr_ovf,
   output logic [7:0]               rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [7:0]               drop_cnt,
   output logic                     rts_stop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] HI_C    = CW'(HIGH_MARK);
   localparam logic [CW-1:0] LO_C    = CW'(LOW_MARK);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic {GO = 1'b0, STOP = 1'b1} rts_e;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    drop_q, drop_d;
   rts_e          state_q, state_d;

   logic pop_ok, wr_ok, drop;

   assign full     = (count_q == DEPTH_C);
   assign rd_valid = (count_q != '0);
   assign count    = count_q;
   assign rd_data  = mem_q[rd_ptr_q];
   assign overflow = ovf_q;
   assign drop_cnt = drop_q;

   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign pop_ok = rd_ack & ~flush & rd_valid;
   assign wr_ok  = wr_stb & ~flush & (~full | pop_ok);
   assign drop   = wr_stb & ~flush & full & ~pop_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (wr_ok && !pop_ok)
            count_d = count_q + CNT_ONE;
         else if (!wr_ok && pop_ok)
            count_d = count_q - CNT_ONE;
      end
   end

   // A drop in the same cycle as a clear leaves exactly one recorded drop.
   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (clr_ovf)
            drop_d = 8'd1;
         else if (drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
      end else if (clr_ovf) begin
         ovf_d  = 1'b0;
         drop_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= GO;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         GO:   if (count_d >= HI_C) state_d = STOP;
         STOP: if (count_d <= LO_C) state_d = GO;
         default: state_d = GO;
      endcase
   end

   always_comb begin
      rts_stop = (state_q == STOP);
   end

endmodule
